// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types, default image geometry and 3x3 slot offsets for the window fetcher.
package sobel_pkg;
  typedef logic [7:0] pixel_t;
  typedef enum logic [2:0] {IDLE, CALC, ISSUE_RD, WAIT_RD, WIN_RDY, ISSUE_WR, WAIT_WR, DONE} state_t;
  localparam int IMG_W_DEF = 8;
  localparam int IMG_H_DEF = 8;
  localparam int OUT_BASE_DEF = 128;
  localparam int SLOT_DR [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int SLOT_DC [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
endpackage

// File: rtl/neighbour_addr_gen.sv
// neighbour_addr_gen: raster address and in-image flag for window slot k around a centre pixel.
module neighbour_addr_gen import sobel_pkg::*; #(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic [7:0] center,
  input  logic [3:0] slot,
  output logic [7:0] addr,
  output logic       in_img
);
  localparam int CW = $clog2(IMG_W);
  int row, col, nr, nc;
  always_comb begin
    row = int'(center) >> CW;
    col = int'(center) & (IMG_W - 1);
    nr = row + ((slot > 4'd8) ? 0 : SLOT_DR[slot]);
    nc = col + ((slot > 4'd8) ? 0 : SLOT_DC[slot]);
    // a centre beyond the image has no in-image neighbours at all
    in_img = (int'(center) < IMG_W * IMG_H) && (slot <= 4'd8) &&
             (nr >= 0) && (nr < IMG_H) && (nc >= 0) && (nc < IMG_W);
    addr = in_img ? 8'(nr * IMG_W + nc) : 8'd0;
  end
endmodule

// File: rtl/window_fetch_ctrl.sv
// window_fetch_ctrl: gathers a 3x3 pixel window through Read_Write, then writes back the Sobel result.
module window_fetch_ctrl import sobel_pkg::*; #(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int OUT_BASE = OUT_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  center_addr,
  output logic        start_read,
  output logic [7:0]  addr_r_mc,
  input  logic        read_data_done,
  input  pixel_t      data_r_o,
  output logic        start_write,
  output logic [7:0]  addr_w_mc,
  output pixel_t      data_w,
  input  logic        write_done,
  output logic [71:0] window,
  output logic        window_valid,
  input  pixel_t      result,
  input  logic        result_valid,
  output logic        active,
  output logic        done
);
  state_t state, state_n;
  logic [7:0] center, center_n, addr_r_n, addr_w_n, nb_addr;
  logic [3:0] k, k_n;
  logic [71:0] window_n;
  pixel_t data_w_n;
  logic nb_in;
  neighbour_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_nb (
    .center(center),
    .slot(k),
    .addr(nb_addr),
    .in_img(nb_in)
  );
  always_comb begin
    state_n = state;
    center_n = center;
    k_n = k;
    window_n = window;
    addr_r_n = addr_r_mc;
    addr_w_n = addr_w_mc;
    data_w_n = data_w;
    case (state)
      IDLE: if (start) begin
        center_n = center_addr;
        k_n = 4'd0;
        window_n = '0;
        state_n = CALC;
      end
      CALC: if (nb_in) begin
        addr_r_n = nb_addr;
        state_n = ISSUE_RD;
      end else begin
        k_n = k + 4'd1;
        state_n = (k == 4'd8) ? WIN_RDY : CALC;
      end
      ISSUE_RD: state_n = WAIT_RD;
      WAIT_RD: if (read_data_done) begin
        window_n[{k, 3'b000} +: 8] = data_r_o;
        k_n = k + 4'd1;
        state_n = (k == 4'd8) ? WIN_RDY : CALC;
      end
      WIN_RDY: if (result_valid) begin
        data_w_n = result;
        addr_w_n = 8'(OUT_BASE + int'(center));
        state_n = ISSUE_WR;
      end
      ISSUE_WR: state_n = WAIT_WR;
      WAIT_WR: state_n = write_done ? DONE : WAIT_WR;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // strobes are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      center <= '0;
      k <= '0;
      window <= '0;
      addr_r_mc <= '0;
      addr_w_mc <= '0;
      data_w <= '0;
      start_read <= 1'b0;
      start_write <= 1'b0;
      window_valid <= 1'b0;
      active <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      center <= center_n;
      k <= k_n;
      window <= window_n;
      addr_r_mc <= addr_r_n;
      addr_w_mc <= addr_w_n;
      data_w <= data_w_n;
      start_read <= state_n == ISSUE_RD;
      start_write <= state_n == ISSUE_WR;
      window_valid <= state_n == WIN_RDY;
      active <= state_n != IDLE;
      done <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_window_fetch_ctrl.sv
// tb_window_fetch_ctrl: randomized bench with a memory-backed Read_Write responder and a geometric window model.
module tb_window_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] center_addr = '0;
  logic start_read, start_write, window_valid, active, done;
  logic [7:0] addr_r_mc, addr_w_mc, data_w;
  logic read_data_done = 1'b0;
  logic write_done = 1'b0;
  logic [7:0] data_r_o = '0;
  logic [7:0] result = '0;
  logic result_valid = 1'b0;
  logic [71:0] window;

  always #5 clk = ~clk;

  window_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .center_addr(center_addr),
    .start_read(start_read), .addr_r_mc(addr_r_mc), .read_data_done(read_data_done),
    .data_r_o(data_r_o), .start_write(start_write), .addr_w_mc(addr_w_mc),
    .data_w(data_w), .write_done(write_done), .window(window),
    .window_valid(window_valid), .result(result), .result_valid(result_valid),
    .active(active), .done(done)
  );

  logic [7:0] mem [256];
  int rd_delay = 1, wr_delay = 1, rd_cnt = 0, wr_cnt = 0;
  int done_count = 0, wr_count = 0;
  logic [7:0] rd_addr = '0, wr_addr_obs = '0, wr_data_obs = '0;
  bit addr_moved = 0, timed_out = 0, win_stable = 0;
  logic [7:0] rd_log[$];
  logic [7:0] exp_reads[$];
  logic [71:0] exp_win, obs_win;
  int checks = 0, errors = 0;

  // Read_Write stand-in: serves reads from mem after rd_delay cycles, acknowledges writes after wr_delay
  always @(posedge clk) begin
    #1;
    read_data_done = 1'b0;
    write_done = 1'b0;
    data_r_o = 8'($urandom);
    if (rst) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (done) done_count++;
      if (start_read) begin
        rd_log.push_back(addr_r_mc);
        rd_addr = addr_r_mc;
        rd_cnt = rd_delay;
      end else if (rd_cnt > 0) begin
        if (addr_r_mc !== rd_addr) addr_moved = 1;
        rd_cnt--;
        if (rd_cnt == 0) begin
          read_data_done = 1'b1;
          data_r_o = mem[rd_addr];
        end
      end
      if (start_write) begin
        wr_count++;
        wr_addr_obs = addr_w_mc;
        wr_data_obs = data_w;
        wr_cnt = wr_delay;
      end else if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) write_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected reads and window from image geometry on the default 8x8 image
  function automatic void model(input logic [7:0] c);
    int r, col;
    exp_reads.delete();
    exp_win = '0;
    for (int s = 0; s < 9; s++) begin
      r = int'(c) / 8 + s / 3 - 1;
      col = int'(c) % 8 + s % 3 - 1;
      if (c < 64 && r >= 0 && r < 8 && col >= 0 && col < 8) begin
        exp_reads.push_back(8'(r * 8 + col));
        exp_win[s * 8 +: 8] = mem[r * 8 + col];
      end
    end
  endfunction

  function automatic bit reads_match();
    if (rd_log.size() != exp_reads.size()) return 0;
    foreach (rd_log[i]) if (rd_log[i] !== exp_reads[i]) return 0;
    return 1;
  endfunction

  task automatic run_op(input logic [7:0] c, input logic [7:0] res, input bit dup);
    int n;
    bit dup_done;
    rd_log.delete();
    done_count = 0;
    wr_count = 0;
    addr_moved = 0;
    timed_out = 0;
    dup_done = 0;
    center_addr = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    center_addr = 8'($urandom);
    n = 0;
    while (!window_valid && n < 400) begin
      if (dup && !dup_done && start_read) begin
        tick();
        start = 1'b1;
        center_addr = 8'd5;
        tick();
        start = 1'b0;
        dup_done = 1;
      end else tick();
      n++;
    end
    if (n >= 400) timed_out = 1;
    obs_win = window;
    tick();
    tick();
    win_stable = window_valid && (window === obs_win);
    result = res;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    result = 8'($urandom);
    n = 0;
    while (done_count == 0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) timed_out = 1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({start_read, addr_r_mc, start_write, addr_w_mc, data_w, window, window_valid, active, done} !== '0) begin
      errors++;
      $display("FAIL reset_hold outputs not zero: win=%h ar=%h aw=%h act=%b", window, addr_r_mc, addr_w_mc, active);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({start_read, start_write, window_valid, active, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_release strobes=%b required 00000", {start_read, start_write, window_valid, active, done});
    end
  endtask

  task automatic test_center27();
    rd_delay = 1;
    wr_delay = 1;
    model(8'd27);
    run_op(8'd27, 8'h5a, 0);
    checks++;
    if (timed_out || !reads_match()) begin
      errors++;
      $display("FAIL c27_reads got %0d reads (timeout=%0b) required %0d", rd_log.size(), timed_out, exp_reads.size());
    end
    checks++;
    if (obs_win !== exp_win || !win_stable) begin
      errors++;
      $display("FAIL c27_window got %h stable=%0b required %h", obs_win, win_stable, exp_win);
    end
    checks++;
    if (wr_addr_obs !== 8'd155 || wr_data_obs !== 8'h5a || wr_count != 1) begin
      errors++;
      $display("FAIL c27_write got addr %0d data %h n=%0d required 155 5a 1", wr_addr_obs, wr_data_obs, wr_count);
    end
    checks++;
    if (done_count != 1) begin
      errors++;
      $display("FAIL c27_done got %0d pulses required 1", done_count);
    end
  endtask

  task automatic test_edges();
    model(8'd0);
    run_op(8'd0, 8'h11, 0);
    checks++;
    if (!reads_match() || obs_win !== exp_win) begin
      errors++;
      $display("FAIL c0_window got %0d reads win %h required %0d reads win %h", rd_log.size(), obs_win, exp_reads.size(), exp_win);
    end
    checks++;
    if (wr_addr_obs !== 8'd128 || done_count != 1) begin
      errors++;
      $display("FAIL c0_write got addr %0d done %0d required 128 1", wr_addr_obs, done_count);
    end
    model(8'd63);
    run_op(8'd63, 8'h22, 0);
    checks++;
    if (!reads_match() || obs_win !== exp_win) begin
      errors++;
      $display("FAIL c63_window got %0d reads win %h required %0d reads win %h", rd_log.size(), obs_win, exp_reads.size(), exp_win);
    end
    checks++;
    if (wr_addr_obs !== 8'd191 || wr_data_obs !== 8'h22) begin
      errors++;
      $display("FAIL c63_write got addr %0d data %h required 191 22", wr_addr_obs, wr_data_obs);
    end
  endtask

  task automatic test_slow_read();
    rd_delay = 5;
    model(8'd27);
    run_op(8'd27, 8'h77, 0);
    checks++;
    if (!reads_match() || addr_moved) begin
      errors++;
      $display("FAIL slow_read got %0d read pulses addr_moved=%0b required %0d stable", rd_log.size(), addr_moved, exp_reads.size());
    end
    checks++;
    if (obs_win !== exp_win) begin
      errors++;
      $display("FAIL slow_window got %h required %h", obs_win, exp_win);
    end
  endtask

  task automatic test_second_start();
    rd_delay = 5;
    model(8'd27);
    run_op(8'd27, 8'h3c, 1);
    checks++;
    if (done_count != 1 || wr_count != 1 || wr_addr_obs !== 8'd155) begin
      errors++;
      $display("FAIL dup_start got done %0d writes %0d addr %0d required 1 1 155", done_count, wr_count, wr_addr_obs);
    end
    checks++;
    if (!reads_match() || obs_win !== exp_win) begin
      errors++;
      $display("FAIL dup_window got %0d reads win %h required %0d win %h", rd_log.size(), obs_win, exp_reads.size(), exp_win);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    rd_delay = 6;
    center_addr = 8'd27;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!start_read && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({start_read, addr_r_mc, start_write, addr_w_mc, data_w, window, window_valid, active, done} !== '0) begin
      errors++;
      $display("FAIL mid_reset outputs not zero: ar=%h win=%h act=%b timeout=%0b", addr_r_mc, window, active, n >= 50);
    end
    tick();
    rst = 1'b0;
    rd_log.delete();
    repeat (8) tick();
    checks++;
    if (active !== 1'b0 || rd_log.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_idle active=%b reads=%0d required 0 0", active, rd_log.size());
    end
    rd_delay = 1;
    model(8'd27);
    run_op(8'd27, 8'h33, 0);
    checks++;
    if (!reads_match() || obs_win !== exp_win || wr_data_obs !== 8'h33 || done_count != 1) begin
      errors++;
      $display("FAIL mid_reset_rerun reads %0d win %h data %h done %0d required %0d %h 33 1",
               rd_log.size(), obs_win, wr_data_obs, done_count, exp_reads.size(), exp_win);
    end
  endtask

  task automatic test_random();
    logic [7:0] c, res;
    for (int i = 0; i < 12; i++) begin
      c = 8'($urandom_range(0, 135));
      res = 8'($urandom);
      rd_delay = $urandom_range(1, 4);
      wr_delay = $urandom_range(1, 4);
      model(c);
      run_op(c, res, 0);
      checks++;
      if (timed_out || !reads_match() || obs_win !== exp_win) begin
        errors++;
        $display("FAIL rand_window c=%0d got %0d reads win %h required %0d win %h", c, rd_log.size(), obs_win, exp_reads.size(), exp_win);
      end
      checks++;
      if (wr_addr_obs !== 8'(128 + int'(c)) || wr_data_obs !== res || done_count != 1) begin
        errors++;
        $display("FAIL rand_write c=%0d got addr %0d data %h done %0d required %0d %h 1",
                 c, wr_addr_obs, wr_data_obs, done_count, (128 + int'(c)) % 256, res);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #12;
    test_reset();
    test_center27();
    test_edges();
    test_slow_read();
    test_second_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
